dmem_multicycle: RTL and testbench

Parametrised data memory that replaces the single-cycle Dmem on the processor's Memory-stage interface. It services each load or store over a configurable number of cycles and adds per-byte write enables and address-error detection. It drives a stall signal into the hazard logic so the core holds the Memory stage until the access completes. It sits between the ARM core's ALUOutM/WriteDataM/MemWriteM outputs and its ReadDataM input.

---
 rtl/dmem_multicycle.sv | 169 ++++++++++++++++
 tb/tb_dmem_multicycle.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_multicycle.sv
// dmem_multicycle
// ---------------
// Multi-cycle data memory for the Memory stage of the core. Each load or
// store is accepted in IDLE, runs for LATENCY stalled cycles and completes
// in a single DONE cycle.
//
// Handshake: MemReqM acts as "valid" and ~StallMemM as "ready". An access
// is accepted on a clock edge where the FSM is in IDLE and MemReqM=1. The
// core must hold every M-stage input until the DONE cycle, where StallMemM
// is 0. The core advances at the end of DONE. A request seen during DONE
// belongs to the completing instruction, so it is never accepted.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   MemReqM      load/store present in the Memory stage
//   MemWriteM    1 = store, 0 = load (sampled at accept)
//   ByteEnM      per-byte store enables
//   DataAdrM     byte address
//   WriteDataM   store data
//   ReadDataM    registered load data, stable between DONE cycles
//   StallMemM    hold F/D/E/M this cycle
//   MemDoneM     one-cycle completion pulse
//   AddrErrM     one-cycle illegal-access pulse, coincident with MemDoneM
//   state_dbg    current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module dmem_multicycle #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MemReqM,
  input  logic               MemWriteM,
  input  logic [WIDTH/8-1:0] ByteEnM,
  input  logic [31:0]        DataAdrM,
  input  logic [WIDTH-1:0]   WriteDataM,
  output logic [WIDTH-1:0]   ReadDataM,
  output logic               StallMemM,
  output logic               MemDoneM,
  output logic               AddrErrM,
  output logic [1:0]         state_dbg
);

  localparam int NB = WIDTH / 8;
  localparam int BO = $clog2(NB);
  localparam int AW = $clog2(DEPTH);
  // Address bits allowed to be non-zero: only the word index field.
  localparam logic [31:0] IDX_MASK = 32'((DEPTH - 1) << BO);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [NB-1:0]     be_q, be_d;
  logic [31:0]       adr_q, adr_d;
  logic [WIDTH-1:0]  wd_q, wd_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              commit;
  logic              acc_we;
  logic [NB-1:0]     acc_be;
  logic [31:0]       acc_adr;
  logic [WIDTH-1:0]  acc_wd;
  logic              acc_err;
  logic [AW-1:0]     acc_idx;

  // The commit edge normally uses the captured copy. With LATENCY=1 the
  // commit edge is the accept edge itself, so the live inputs are used.
  always_comb begin
    acc_we  = we_q;
    acc_be  = be_q;
    acc_adr = adr_q;
    acc_wd  = wd_q;
    if (state_q == IDLE) begin
      acc_we  = MemWriteM;
      acc_be  = ByteEnM;
      acc_adr = DataAdrM;
      acc_wd  = WriteDataM;
    end
    acc_err = |(acc_adr & ~IDX_MASK);
    acc_idx = acc_adr[BO +: AW];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemReqM) begin
          we_d  = MemWriteM;
          be_d  = ByteEnM;
          adr_d = DataAdrM;
          wd_d  = WriteDataM;
          cnt_d = CNT_INIT;
          if (LATENCY == 1) begin
            state_d = DONE;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          commit  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rdata_d = rdata_q;
    if (commit && !acc_we) begin
      rdata_d = acc_err ? '0 : mem[acc_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      adr_q   <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is not reset; reset also blocks any write on an edge it overlaps.
  always_ff @(posedge clk) begin
    if (commit && acc_we && !acc_err && !reset) begin
      for (int i = 0; i < NB; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wd[8*i +: 8];
        end
      end
    end
  end

  assign ReadDataM = rdata_q;
  assign StallMemM = ((state_q == IDLE) && MemReqM) || (state_q == BUSY);
  assign MemDoneM  = (state_q == DONE);
  assign AddrErrM  = (state_q == DONE) && (|(adr_q & ~IDX_MASK));
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dmem_multicycle.sv
// tb_dmem_multicycle
// ------------------
// Directed bench for dmem_multicycle. Three instances share clock, reset
// and data inputs but each has its own request line:
//   k=0: LATENCY=2, k=1: LATENCY=1, k=2: LATENCY=15 (WIDTH=32, DEPTH=64).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
module tb_dmem_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] adr;
  logic [31:0] wd;

  logic [31:0] rdata [3];
  logic        stall [3];
  logic        mdone [3];
  logic        aerr  [3];
  logic [1:0]  st    [3];

  int checks = 0;
  int fails  = 0;
  int lat [3] = '{2, 1, 15};

  always #5 clk = ~clk;

  dmem_multicycle #(.WIDTH(32), .DEPTH(64), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .MemReqM(req[0]), .MemWriteM(we), .ByteEnM(be),
    .DataAdrM(adr), .WriteDataM(wd), .ReadDataM(rdata[0]), .StallMemM(stall[0]),
    .MemDoneM(mdone[0]), .AddrErrM(aerr[0]), .state_dbg(st[0]));

  dmem_multicycle #(.WIDTH(32), .DEPTH(64), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .MemReqM(req[1]), .MemWriteM(we), .ByteEnM(be),
    .DataAdrM(adr), .WriteDataM(wd), .ReadDataM(rdata[1]), .StallMemM(stall[1]),
    .MemDoneM(mdone[1]), .AddrErrM(aerr[1]), .state_dbg(st[1]));

  dmem_multicycle #(.WIDTH(32), .DEPTH(64), .LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset), .MemReqM(req[2]), .MemWriteM(we), .ByteEnM(be),
    .DataAdrM(adr), .WriteDataM(wd), .ReadDataM(rdata[2]), .StallMemM(stall[2]),
    .MemDoneM(mdone[2]), .AddrErrM(aerr[2]), .state_dbg(st[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on instance k; request held until the DONE cycle is seen.
  // With jit set, all inputs are scrambled after the accept edge.
  task automatic access(input int k, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d, input bit jit,
                        output int nstall, output int done_cyc, output logic e);
    we = w; be = b; adr = a; wd = d; req[k] = 1'b1;
    nstall = 0; done_cyc = -1; e = 1'b0;
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (stall[k]) nstall++;
      if (mdone[k]) begin
        done_cyc = c;
        e = aerr[k];
      end
      @(posedge clk); #1;
      if (jit && done_cyc < 0) begin
        req[k] = 1'($urandom_range(0, 1));
        we     = 1'($urandom_range(0, 1));
        be     = 4'($urandom_range(0, 15));
        adr    = $urandom;
        wd     = $urandom;
      end
    end
    req[k] = 1'b0;
  endtask

  task automatic do_acc(input int k, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d, input logic exp_err,
                        input bit jit, input string tag, output logic [31:0] rd);
    int nstall, done_cyc;
    logic e;
    access(k, w, b, a, d, jit, nstall, done_cyc, e);
    chk({tag, "_stall_cycles"}, 32'(nstall), 32'(lat[k]));
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(lat[k]));
    chk({tag, "_addr_err"}, {31'd0, e}, {31'd0, exp_err});
    chk({tag, "_idle_after"}, {30'd0, st[k]}, 32'd0);
    rd = rdata[k];
  endtask

  // Loads with MemReqM held high for ncyc cycles.
  task automatic burst(input int k, input int ncyc, input logic [31:0] a,
                       output int ndone, output int nstall);
    we = 1'b0; be = 4'hF; adr = a; req[k] = 1'b1;
    ndone = 0; nstall = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (stall[k]) nstall++;
      if (mdone[k]) ndone++;
      @(posedge clk); #1;
    end
    req[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int nd, ns;

    reset = 1'b1; req = 3'b000; we = 1'b0; be = 4'h0; adr = 32'h0; wd = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdata", rdata[k], 32'h0);
      chk("rst_stall", {31'd0, stall[k]}, 32'd0);
      chk("rst_done",  {31'd0, mdone[k]}, 32'd0);
      chk("rst_err",   {31'd0, aerr[k]}, 32'd0);
      chk("rst_state", {30'd0, st[k]}, 32'd0);
    end
    @(posedge clk); #1;

    // Full-word store then load, LATENCY=2.
    do_acc(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, "st10", rd);
    chk("st10_rdata_hold", rd, 32'h0);
    do_acc(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b0, "ld10", rd);
    chk("ld10_rdata", rd, 32'hDEADBEEF);

    // Single-byte store merges into the existing word.
    do_acc(0, 1'b1, 4'b0001, 32'h10, 32'h000000AA, 1'b0, 1'b0, "stb10", rd);
    chk("stb10_rdata_hold", rd, 32'hDEADBEEF);
    do_acc(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b0, "ld10b", rd);
    chk("ld10b_rdata", rd, 32'hDEADBEAA);

    // All-zero byte enables: legal, no change.
    do_acc(0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 1'b0, 1'b0, "stz10", rd);
    do_acc(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b0, "ld10c", rd);
    chk("ld10c_rdata", rd, 32'hDEADBEAA);

    // Address errors: misaligned load, out-of-range store aliasing word 0.
    do_acc(0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, "st0", rd);
    do_acc(0, 1'b0, 4'hF, 32'h12, 32'h0, 1'b1, 1'b0, "ld12", rd);
    chk("ld12_rdata_zero", rd, 32'h0);
    do_acc(0, 1'b1, 4'hF, 32'h400, 32'h12345678, 1'b1, 1'b0, "st400", rd);
    do_acc(0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, "ld0", rd);
    chk("ld0_rdata", rd, 32'hCAFEF00D);

    // LATENCY=1: back-to-back loads with request held high.
    do_acc(1, 1'b1, 4'hF, 32'h8, 32'h11223344, 1'b0, 1'b0, "l1_st8", rd);
    burst(1, 6, 32'h8, nd, ns);
    chk("l1_burst_dones", 32'(nd), 32'd3);
    chk("l1_burst_stalls", 32'(ns), 32'd3);
    chk("l1_burst_rdata", rdata[1], 32'h11223344);

    // LATENCY=15: same pattern.
    do_acc(2, 1'b1, 4'hF, 32'h8, 32'h55667788, 1'b0, 1'b0, "l15_st8", rd);
    burst(2, 48, 32'h8, nd, ns);
    chk("l15_burst_dones", 32'(nd), 32'd3);
    chk("l15_burst_stalls", 32'(ns), 32'd45);
    chk("l15_burst_rdata", rdata[2], 32'h55667788);

    // Reset in the middle of a LATENCY=15 store aborts it.
    do_acc(2, 1'b1, 4'hF, 32'h20, 32'h0BADF00D, 1'b0, 1'b0, "l15_st20", rd);
    do_acc(2, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 1'b0, "l15_ld20", rd);
    chk("l15_ld20_rdata", rd, 32'h0BADF00D);
    we = 1'b1; be = 4'hF; adr = 32'h20; wd = 32'hFFFFFFFF; req[2] = 1'b1;
    @(posedge clk); #1;
    req[2] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", {30'd0, st[2]}, 32'd1);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("abort_state", {30'd0, st[2]}, 32'd0);
    chk("abort_rdata", rdata[2], 32'h0);
    chk("abort_stall", {31'd0, stall[2]}, 32'd0);
    @(posedge clk); #1;
    do_acc(2, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 1'b0, "abort_ld20", rd);
    chk("abort_ld20_rdata", rd, 32'h0BADF00D);

    // Inputs scrambled during BUSY; committed store uses captured values.
    do_acc(2, 1'b1, 4'hF, 32'h24, 32'h13579BDF, 1'b0, 1'b1, "jit_st24", rd);
    do_acc(2, 1'b0, 4'hF, 32'h24, 32'h0, 1'b0, 1'b0, "jit_ld24", rd);
    chk("jit_ld24_rdata", rd, 32'h13579BDF);
    do_acc(2, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 1'b0, "jit_ld20", rd);
    chk("jit_ld20_rdata", rd, 32'h0BADF00D);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
